// File: rtl/ring_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_mon_pkg
// Description : Shared types and constants for the ring-counter monitor.
//               Holds the tracking FSM state encoding, the ring width, the
//               reset seed for the "previous sample" register and a rotate
//               helper that produces the expected next ring value.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_mon_pkg;

  localparam int RING_W = 4;
  localparam logic [RING_W-1:0] RING_SEED = 4'b0001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } ring_state_t;

  // A healthy ring advances by rotating left one position (1000 -> 0001).
  function automatic logic [RING_W-1:0] ring_rotl1(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_counter_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_monitor_if
// Description : Sample/status bundle between a ring-counter source and the
//               monitor.
//   master : drives ring_in/ring_vld, observes the monitor status
//   slave  : the monitor - consumes samples, drives status outputs
//   ring_in    [4]      sampled ring value
//   ring_vld   [1]      ring_in valid
//   idx        [2]      binary position of last legal one-hot sample
//   idx_vld    [1]      pulse, idx refreshed
//   lock       [1]      monitor is locked
//   seq_err    [1]      pulse, one-hot but out of sequence
//   onehot_err [1]      pulse, sample not one-hot
//   wrap_cnt   [WRAP_W] saturating wrap count while locked
//   err_cnt    [8]      saturating error count (0 when not built)
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_counter_monitor_if #(
  parameter int WRAP_W = 8
);

  logic [ring_mon_pkg::RING_W-1:0] ring_in;
  logic                            ring_vld;
  logic [1:0]                      idx;
  logic                            idx_vld;
  logic                            lock;
  logic                            seq_err;
  logic                            onehot_err;
  logic [WRAP_W-1:0]               wrap_cnt;
  logic [7:0]                      err_cnt;

  modport master (
    output ring_in, ring_vld,
    input  idx, idx_vld, lock, seq_err, onehot_err, wrap_cnt, err_cnt
  );

  modport slave (
    input  ring_in, ring_vld,
    output idx, idx_vld, lock, seq_err, onehot_err, wrap_cnt, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ring_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : ring_onehot_dec
// Description : Combinational one-hot checker and encoder for a 4-bit ring.
//   i_vec       [4]  ring sample
//   o_idx       [2]  binary position of the set bit (0 when not one-hot)
//   o_is_onehot [1]  exactly one bit of i_vec is set
// Revision    : 1.0 - initial release
// ============================================================================
module ring_onehot_dec
  import ring_mon_pkg::*;
(
  input  wire logic [RING_W-1:0] i_vec,
  output logic      [1:0]        o_idx,
  output logic                   o_is_onehot
);

  always_comb begin
    o_idx       = 2'd0;
    o_is_onehot = 1'b0;
    unique case (i_vec)
      4'b0001: begin o_idx = 2'd0; o_is_onehot = 1'b1; end
      4'b0010: begin o_idx = 2'd1; o_is_onehot = 1'b1; end
      4'b0100: begin o_idx = 2'd2; o_is_onehot = 1'b1; end
      4'b1000: begin o_idx = 2'd3; o_is_onehot = 1'b1; end
      default: begin o_idx = 2'd0; o_is_onehot = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ring_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_monitor
// Description : Watches a sampled 4-bit ring counter. Hunts for a one-hot
//               value, tracks the rotate-left sequence and declares lock
//               after LOCK_N consecutive legal steps. Flags out-of-sequence
//               and non-one-hot samples and counts 1000->0001 wraps while
//               locked. All outputs are registered (latency 1).
//   clk    [1]  rising-edge clock
//   rst_n  [1]  asynchronous active-low reset
//   bus         ring_counter_monitor_if.slave (samples in, status out)
// Build option: define RING_MON_ERRCNT_EN to build the saturating error
//               counter; otherwise err_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_counter_monitor
  import ring_mon_pkg::*;
#(
  parameter int WRAP_W = 8,
  parameter int LOCK_N = 3
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  ring_counter_monitor_if.slave   bus
);

  localparam int              c_GOOD_W    = $clog2(LOCK_N + 1);
  // Lock is reached on the match that takes good_cnt from LOCK_N-1 to LOCK_N.
  localparam [c_GOOD_W-1:0]   c_LOCK_LAST = c_GOOD_W'(LOCK_N - 1);

  ring_state_t         r_state;
  logic [RING_W-1:0]   r_prev;
  logic [c_GOOD_W-1:0] r_good_cnt;
  logic [1:0]          r_idx;
  logic                r_idx_vld;
  logic                r_lock;
  logic                r_seq_err;
  logic                r_onehot_err;
  logic [WRAP_W-1:0]   r_wrap_cnt;

  logic [1:0]          w_idx;
  logic                w_is_onehot;
  logic [RING_W-1:0]   w_expect;
  logic                w_match;
  logic                w_wrap;

  ring_onehot_dec u_dec (
    .i_vec       (bus.ring_in),
    .o_idx       (w_idx),
    .o_is_onehot (w_is_onehot)
  );

  assign w_expect = ring_rotl1(r_prev);
  assign w_match  = (bus.ring_in == w_expect);
  // A matching sample following 1000 is necessarily the 1000->0001 wrap.
  assign w_wrap   = w_match && r_prev[RING_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_prev       <= RING_SEED;
      r_good_cnt   <= '0;
      r_idx        <= 2'd0;
      r_idx_vld    <= 1'b0;
      r_lock       <= 1'b0;
      r_seq_err    <= 1'b0;
      r_onehot_err <= 1'b0;
      r_wrap_cnt   <= '0;
    end else begin
      r_idx_vld    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_onehot_err <= 1'b0;
      if (bus.ring_vld) begin
        if (!w_is_onehot) begin
          // prev, idx and good_cnt deliberately hold across a corrupt sample.
          r_onehot_err <= 1'b1;
          r_state      <= HUNT;
          r_lock       <= 1'b0;
        end else begin
          r_idx     <= w_idx;
          r_idx_vld <= 1'b1;
          unique case (r_state)
            HUNT: begin
              r_prev     <= bus.ring_in;
              r_good_cnt <= '0;
              r_state    <= TRACK;
            end
            TRACK: begin
              r_prev <= bus.ring_in;
              if (w_match) begin
                r_good_cnt <= r_good_cnt + 1'b1;
                if (r_good_cnt == c_LOCK_LAST) begin
                  r_state <= LOCKED;
                  r_lock  <= 1'b1;
                end
              end else begin
                r_seq_err  <= 1'b1;
                r_good_cnt <= '0;
              end
            end
            LOCKED: begin
              r_prev <= bus.ring_in;
              if (w_match) begin
                if (w_wrap && (r_wrap_cnt != {WRAP_W{1'b1}})) begin
                  r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
              end else begin
                r_seq_err  <= 1'b1;
                r_good_cnt <= '0;
                r_state    <= TRACK;
                r_lock     <= 1'b0;
              end
            end
            default: begin
              r_state <= HUNT;
              r_lock  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef RING_MON_ERRCNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  // Same conditions that raise seq_err or onehot_err in the FSM above.
  assign w_err_evt = bus.ring_vld &&
                     (!w_is_onehot || ((r_state != HUNT) && !w_match));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.idx        = r_idx;
  assign bus.idx_vld    = r_idx_vld;
  assign bus.lock       = r_lock;
  assign bus.seq_err    = r_seq_err;
  assign bus.onehot_err = r_onehot_err;
  assign bus.wrap_cnt   = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_counter_monitor
// Description : Directed table-driven bench for ring_counter_monitor. Two
//               instances share one stimulus stream: WRAP_W=8 and WRAP_W=2
//               (the latter exercises wrap counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter_monitor;

`ifdef RING_MON_ERRCNT_EN
  localparam bit c_ERRCNT_ON = 1'b1;
`else
  localparam bit c_ERRCNT_ON = 1'b0;
`endif

  typedef struct {
    logic       vld;
    logic [3:0] ring;
    logic [1:0] idx;
    logic       iv;
    logic       lk;
    logic       se;
    logic       oe;
    logic [7:0] w8;
    logic [1:0] w2;
    logic [7:0] err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_vld = 1'b0;
  logic [3:0] r_ring = 4'b0000;
  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  ring_counter_monitor_if #(.WRAP_W(8)) bus8 ();
  ring_counter_monitor_if #(.WRAP_W(2)) bus2 ();

  assign bus8.ring_in  = r_ring;
  assign bus8.ring_vld = r_vld;
  assign bus2.ring_in  = r_ring;
  assign bus2.ring_vld = r_vld;

  ring_counter_monitor #(.WRAP_W(8), .LOCK_N(3)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  ring_counter_monitor #(.WRAP_W(2), .LOCK_N(3)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    logic [7:0] exp_err;
    exp_err = c_ERRCNT_ON ? e.err : 8'd0;
    chk({tag, " idx"},        32'(bus8.idx),        32'(e.idx));
    chk({tag, " idx_vld"},    32'(bus8.idx_vld),    32'(e.iv));
    chk({tag, " lock"},       32'(bus8.lock),       32'(e.lk));
    chk({tag, " seq_err"},    32'(bus8.seq_err),    32'(e.se));
    chk({tag, " onehot_err"}, 32'(bus8.onehot_err), 32'(e.oe));
    chk({tag, " err_excl"},   32'(bus8.seq_err & bus8.onehot_err), 32'd0);
    chk({tag, " wrap_cnt"},   32'(bus8.wrap_cnt),   32'(e.w8));
    chk({tag, " err_cnt"},    32'(bus8.err_cnt),    32'(exp_err));
    chk({tag, " w2.wrap_cnt"}, 32'(bus2.wrap_cnt),  32'(e.w2));
    chk({tag, " w2.lock"},     32'(bus2.lock),      32'(e.lk));
    chk({tag, " w2.err_cnt"},  32'(bus2.err_cnt),   32'(exp_err));
  endtask

  task automatic add(input logic v, input logic [3:0] r, input int ix, input int iv,
                     input int lk, input int se, input int oe, input int w8,
                     input int w2, input int er);
    vec_t t;
    t.vld = v;  t.ring = r;  t.idx = 2'(ix); t.iv = iv[0]; t.lk = lk[0];
    t.se = se[0]; t.oe = oe[0]; t.w8 = 8'(w8); t.w2 = 2'(w2); t.err = 8'(er);
    tbl.push_back(t);
  endtask

  // Drive one cycle of stimulus, then sample outputs 1 ns after the edge.
  task automatic step(input logic v, input logic [3:0] r);
    r_vld  = v;
    r_ring = r;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_vec(input int ix, input int iv, input int lk, input int se,
                         input int oe, input int w8, input int w2, input int er,
                         output vec_t t);
    t.vld = 1'b0; t.ring = 4'b0000;
    t.idx = 2'(ix); t.iv = iv[0]; t.lk = lk[0]; t.se = se[0]; t.oe = oe[0];
    t.w8 = 8'(w8); t.w2 = 2'(w2); t.err = 8'(er);
  endtask

  initial begin
    vec_t e;

    //   vld ring     idx iv lk se oe w8 w2 err
    add(1, 4'b0001,  0, 1, 0, 0, 0, 0, 0, 0);  // HUNT -> TRACK
    add(1, 4'b0010,  1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0100,  2, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 0, 0, 0);  // third legal step -> lock
    add(1, 4'b0001,  0, 1, 1, 0, 0, 1, 1, 0);  // wrap 1
    add(1, 4'b0010,  1, 1, 1, 0, 0, 1, 1, 0);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 1, 1, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 1, 1, 0);
    add(1, 4'b0001,  0, 1, 1, 0, 0, 2, 2, 0);  // wrap 2
    add(1, 4'b0010,  1, 1, 1, 0, 0, 2, 2, 0);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 2, 2, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 2, 2, 0);
    add(1, 4'b0001,  0, 1, 1, 0, 0, 3, 3, 0);  // wrap 3
    add(1, 4'b0010,  1, 1, 1, 0, 0, 3, 3, 0);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 3, 3, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 3, 3, 0);
    add(1, 4'b0001,  0, 1, 1, 0, 0, 4, 3, 0);  // wrap 4, 2-bit saturated
    add(1, 4'b0010,  1, 1, 1, 0, 0, 4, 3, 0);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 4, 3, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 4, 3, 0);
    add(1, 4'b0001,  0, 1, 1, 0, 0, 5, 3, 0);  // wrap 5
    add(1, 4'b0010,  1, 1, 1, 0, 0, 5, 3, 0);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 5, 3, 0);
    add(1, 4'b1000,  3, 1, 1, 0, 0, 5, 3, 0);
    add(1, 4'b0100,  2, 1, 0, 1, 0, 5, 3, 1);  // 0001 expected -> seq_err
    add(1, 4'b1000,  3, 1, 0, 0, 0, 5, 3, 1);
    add(1, 4'b0001,  0, 1, 0, 0, 0, 5, 3, 1);  // wrap in TRACK is not counted
    add(1, 4'b0010,  1, 1, 1, 0, 0, 5, 3, 1);  // relock
    add(0, 4'b1111,  1, 0, 1, 0, 0, 5, 3, 1);  // ring_vld low: garbage ignored
    add(0, 4'b0000,  1, 0, 1, 0, 0, 5, 3, 1);
    add(0, 4'b0110,  1, 0, 1, 0, 0, 5, 3, 1);
    add(0, 4'b1010,  1, 0, 1, 0, 0, 5, 3, 1);
    add(0, 4'b0101,  1, 0, 1, 0, 0, 5, 3, 1);
    add(1, 4'b0100,  2, 1, 1, 0, 0, 5, 3, 1);  // still locked on prev=0010
    add(1, 4'b0110,  2, 0, 0, 0, 1, 5, 3, 2);  // not one-hot
    add(1, 4'b0000,  2, 0, 0, 0, 1, 5, 3, 3);  // zero
    add(1, 4'b0010,  1, 1, 0, 0, 0, 5, 3, 3);  // HUNT: no seq_err
    add(1, 4'b0100,  2, 1, 0, 0, 0, 5, 3, 3);
    add(1, 4'b1000,  3, 1, 0, 0, 0, 5, 3, 3);
    add(1, 4'b0001,  0, 1, 1, 0, 0, 5, 3, 3);  // lock, no wrap counted

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_vec(0, 0, 0, 0, 0, 0, 0, 0, e);
    check_all("reset", e);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].ring);
      check_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset in the middle of a clock period while locked.
    r_vld  = 1'b1;
    r_ring = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    exp_vec(0, 0, 0, 0, 0, 0, 0, 0, e);
    check_all("async_rst", e);
    @(posedge clk);
    #1;
    check_all("rst_hold", e);
    rst_n = 1'b1;

    // First sample after reset is handled as HUNT (0100 would be out of
    // sequence from the 0001 seed if the FSM were tracking).
    step(1'b1, 4'b0100);
    exp_vec(2, 1, 0, 0, 0, 0, 0, 0, e);
    check_all("post_rst_hunt", e);
    step(1'b1, 4'b0110);
    exp_vec(2, 0, 0, 0, 1, 0, 0, 1, e);
    check_all("oh_0110", e);
    step(1'b1, 4'b0000);
    exp_vec(2, 0, 0, 0, 1, 0, 0, 2, e);
    check_all("oh_0000", e);
    // Back in HUNT: 0001 is not rotl(0100) but must not raise seq_err.
    step(1'b1, 4'b0001);
    exp_vec(0, 1, 0, 0, 0, 0, 0, 2, e);
    check_all("hunt_again", e);
    step(1'b0, 4'b1001);
    exp_vec(0, 0, 0, 0, 0, 0, 0, 2, e);
    check_all("idle", e);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_counter_monitor.md
RING_COUNTER_MONITOR -- requirements
Module: ring_counter_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, width of the wrap counter output.
REQ-002 Parameter LOCK_N, default 3, count of consecutive legal transitions needed to assert lock.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ring_in  input  4  sampled 4-bit ring-counter value.
REQ-006 ring_vld  input  1  ring_in is valid this cycle; samples with ring_vld low are ignored.
REQ-007 idx  output  2  binary position of the last valid one-hot sample (0001->0, 0010->1, 0100->2, 1000->3).
REQ-008 idx_vld  output  1  one-cycle pulse: idx updated from a legal one-hot sample.
REQ-009 lock  output  1  high while the FSM is in LOCKED.
REQ-010 seq_err  output  1  one-cycle pulse: a one-hot sample did not match the expected next value while in TRACK or LOCKED.
REQ-011 onehot_err  output  1  one-cycle pulse: a valid sample was not exactly one-hot.
REQ-012 wrap_cnt  output  WRAP_W  saturating count of legal 1000->0001 wraps seen while locked.
REQ-013 err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-014 All outputs are registered; response to a valid sample appears on the cycle after the clk edge that samples it (latency 1).
REQ-015 Expected next value = ring_in_prev rotated left by one (1000 -> 0001).
REQ-016 The FSM has states HUNT, TRACK and LOCKED; it advances only on cycles with ring_vld high.
REQ-017 HUNT: a one-hot sample -> TRACK, with the sample stored as prev and good_cnt=0; a non-one-hot sample stays in HUNT.
REQ-018 TRACK: a sample equal to the expected value increments good_cnt; when good_cnt reaches LOCK_N -> LOCKED.
REQ-019 TRACK or LOCKED, one-hot sample but not the expected value: pulse seq_err, reseed prev with the sample, good_cnt=0, go to TRACK.
REQ-020 Any state, non-one-hot sample (including 0000): pulse onehot_err, go to HUNT; prev, idx and good_cnt hold their values.
REQ-021 In LOCKED, a legal 1000->0001 transition increments wrap_cnt, which saturates at all-ones and never wraps.
REQ-022 idx and idx_vld update on every one-hot sample, in every state.
REQ-023 seq_err and onehot_err are never high in the same cycle.
REQ-024 A cycle with ring_vld low produces no pulses and no state change.

Reset
REQ-025 rst_n low immediately forces: state=HUNT, idx=0, idx_vld=0, lock=0, seq_err=0, onehot_err=0, wrap_cnt=0, err_cnt=0, prev=0001, good_cnt=0.
REQ-026 Reset asserted mid-operation discards lock and all counts; the first valid sample after deassertion is handled as in HUNT.

Configuration
REQ-027 Macro RING_MON_ERRCNT_EN defined: err_cnt increments by 1 on each seq_err or onehot_err pulse and saturates at 255.
REQ-028 Macro RING_MON_ERRCNT_EN undefined: the err_cnt port remains and is tied to 0, and no counter logic is built.

Structure
REQ-029 Package ring_mon_pkg holds the FSM state enum (HUNT/TRACK/LOCKED), constant RING_SEED=4'b0001, and the ring width constant 4.
REQ-030 Sub-module ring_onehot_dec is a combinational block: 4-bit in; 2-bit index plus is_onehot flag out; instantiated once.

Verification
REQ-031 Reset, then 0001,0010,0100,1000 each with ring_vld=1 -> lock=1 one cycle after the 1000 sample; idx sequence 0,1,2,3.
REQ-032 Locked stream continues 1000->0001 three times -> wrap_cnt=3; with WRAP_W=2, 5 wraps -> wrap_cnt holds 3.
REQ-033 Locked stream, then inject 0100 where 0001 is expected -> seq_err pulse, lock=0, state TRACK; 3 further legal steps -> lock=1 again.
REQ-034 Inject 0110, then 0000 -> two onehot_err pulses, state HUNT, idx unchanged; with RING_MON_ERRCNT_EN defined err_cnt=2, otherwise 0.
REQ-035 While locked, toggle ring_vld low for 5 cycles with garbage on ring_in -> no output change; assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for clk.
